// File: rtl/banco_registradores_param_pkg.sv
// Shared defaults and the address-width helper for the parameterised register bank.
package banco_registradores_param_pkg;

  localparam int LARGURA_PADRAO   = 8;
  localparam int NUM_REGS_PADRAO  = 8;
  localparam int NUM_BOOLS_PADRAO = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/banco_registradores_param_if.sv
// Read/write/reserve bus of the register bank; the master drives requests, the slave returns registered reads.
interface banco_registradores_param_if
  import banco_registradores_param_pkg::*;
#(
  parameter int LARGURA   = LARGURA_PADRAO,
  parameter int NUM_REGS  = NUM_REGS_PADRAO,
  parameter int NUM_BOOLS = NUM_BOOLS_PADRAO
);
  localparam int AW = clog2(NUM_REGS);
  localparam int BW = clog2(NUM_BOOLS);

  logic               halt;
  logic [AW-1:0]      regLido1;
  logic [AW-1:0]      regLido2;
  logic [AW-1:0]      regEscrito;
  logic               sobrescrever;
  logic [LARGURA-1:0] dadoEscrito;
  logic [BW-1:0]      boolLido1;
  logic [BW-1:0]      boolLido2;
  logic [BW-1:0]      boolEscrito;
  logic               sobrescreverBool;
  logic               dadoBoolEscrito;
  logic               reservar;
  logic [AW-1:0]      regReservado;
  logic [LARGURA-1:0] dado1;
  logic [LARGURA-1:0] dado2;
  logic               dadoBool1;
  logic               dadoBool2;
  logic               ocupado1;
  logic               ocupado2;

  modport master (
    output halt, regLido1, regLido2, regEscrito, sobrescrever, dadoEscrito,
           boolLido1, boolLido2, boolEscrito, sobrescreverBool, dadoBoolEscrito,
           reservar, regReservado,
    input  dado1, dado2, dadoBool1, dadoBool2, ocupado1, ocupado2
  );

  modport slave (
    input  halt, regLido1, regLido2, regEscrito, sobrescrever, dadoEscrito,
           boolLido1, boolLido2, boolEscrito, sobrescreverBool, dadoBoolEscrito,
           reservar, regReservado,
    output dado1, dado2, dadoBool1, dadoBool2, ocupado1, ocupado2
  );

endinterface

// File: rtl/banco_registradores_param_placar_ocupacao.sv
// Busy-bit scoreboard: a write releases a register, a reservation marks it pending,
// and two lookups return the post-edge busy state one cycle later.
module placar_ocupacao
  import banco_registradores_param_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_PADRAO,
  parameter int ZERO_FIXO = 1,
  parameter int AW        = clog2(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          halt_i,
  input  logic          reservar_i,
  input  logic [AW-1:0] regReservado_i,
  input  logic          liberar_i,
  input  logic [AW-1:0] regLiberado_i,
  input  logic [AW-1:0] regLido1_i,
  input  logic [AW-1:0] regLido2_i,
  output logic          ocupado1_o,
  output logic          ocupado2_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                ocupado1_q;
  logic                ocupado1_d;
  logic                ocupado2_q;
  logic                ocupado2_d;

  function automatic logic enderecoValido(input logic [AW-1:0] addr);
    return (int'(addr) < NUM_REGS) && !((ZERO_FIXO != 0) && (addr == '0));
  endfunction

  // Release is applied before reserve so a same-edge reservation of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (liberar_i && enderecoValido(regLiberado_i)) busy_d[regLiberado_i] = 1'b0;
    if (reservar_i && enderecoValido(regReservado_i)) busy_d[regReservado_i] = 1'b1;
    ocupado1_d = enderecoValido(regLido1_i) ? busy_d[regLido1_i] : 1'b0;
    ocupado2_d = enderecoValido(regLido2_i) ? busy_d[regLido2_i] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      ocupado1_q <= 1'b0;
      ocupado2_q <= 1'b0;
    end else if (!halt_i) begin
      busy_q     <= busy_d;
      ocupado1_q <= ocupado1_d;
      ocupado2_q <= ocupado2_d;
    end
  end

  assign ocupado1_o = ocupado1_q;
  assign ocupado2_o = ocupado2_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Parameterised data/boolean register bank with write bypass, optional hardwired zero
// register and a busy-bit scoreboard for pending writes.
module banco_registradores_param
  import banco_registradores_param_pkg::*;
#(
  parameter int LARGURA   = LARGURA_PADRAO,
  parameter int NUM_REGS  = NUM_REGS_PADRAO,
  parameter int NUM_BOOLS = NUM_BOOLS_PADRAO,
  parameter int ZERO_FIXO = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  banco_registradores_param_if.slave  bus
);

  localparam int AW = clog2(NUM_REGS);
  localparam int BW = clog2(NUM_BOOLS);

  logic [LARGURA-1:0]   banco_q [NUM_REGS];
  logic [LARGURA-1:0]   banco_d [NUM_REGS];
  logic [NUM_BOOLS-1:0] bools_q;
  logic [NUM_BOOLS-1:0] bools_d;
  logic [LARGURA-1:0]   dado1_q;
  logic [LARGURA-1:0]   dado1_d;
  logic [LARGURA-1:0]   dado2_q;
  logic [LARGURA-1:0]   dado2_d;
  logic                 dadoBool1_q;
  logic                 dadoBool1_d;
  logic                 dadoBool2_q;
  logic                 dadoBool2_d;

  function automatic logic regValido(input logic [AW-1:0] addr);
    return (int'(addr) < NUM_REGS) && !((ZERO_FIXO != 0) && (addr == '0));
  endfunction

  function automatic logic boolValido(input logic [BW-1:0] addr);
    return int'(addr) < NUM_BOOLS;
  endfunction

  // Reads look at the post-write contents, which gives same-edge bypass for free.
  always_comb begin
    banco_d = banco_q;
    bools_d = bools_q;
    if (bus.sobrescrever && regValido(bus.regEscrito))
      banco_d[bus.regEscrito] = bus.dadoEscrito;
    if (bus.sobrescreverBool && boolValido(bus.boolEscrito))
      bools_d[bus.boolEscrito] = bus.dadoBoolEscrito;
    dado1_d     = regValido(bus.regLido1)   ? banco_d[bus.regLido1]   : '0;
    dado2_d     = regValido(bus.regLido2)   ? banco_d[bus.regLido2]   : '0;
    dadoBool1_d = boolValido(bus.boolLido1) ? bools_d[bus.boolLido1]  : 1'b0;
    dadoBool2_d = boolValido(bus.boolLido2) ? bools_d[bus.boolLido2]  : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      banco_q     <= '{default: '0};
      bools_q     <= '0;
      dado1_q     <= '0;
      dado2_q     <= '0;
      dadoBool1_q <= 1'b0;
      dadoBool2_q <= 1'b0;
    end else if (!bus.halt) begin
      banco_q     <= banco_d;
      bools_q     <= bools_d;
      dado1_q     <= dado1_d;
      dado2_q     <= dado2_d;
      dadoBool1_q <= dadoBool1_d;
      dadoBool2_q <= dadoBool2_d;
    end
  end

  placar_ocupacao #(
    .NUM_REGS  (NUM_REGS),
    .ZERO_FIXO (ZERO_FIXO),
    .AW        (AW)
  ) uPlacar (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .halt_i         (bus.halt),
    .reservar_i     (bus.reservar),
    .regReservado_i (bus.regReservado),
    .liberar_i      (bus.sobrescrever),
    .regLiberado_i  (bus.regEscrito),
    .regLido1_i     (bus.regLido1),
    .regLido2_i     (bus.regLido2),
    .ocupado1_o     (bus.ocupado1),
    .ocupado2_o     (bus.ocupado2)
  );

  assign bus.dado1     = dado1_q;
  assign bus.dado2     = dado2_q;
  assign bus.dadoBool1 = dadoBool1_q;
  assign bus.dadoBool2 = dadoBool2_q;

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench: the driver queues hand-computed expectations per edge, a monitor checks them.
module tb_banco_registradores_param;
  import banco_registradores_param_pkg::*;

  localparam int LARGURA   = 8;
  localparam int NUM_REGS  = 8;
  localparam int NUM_BOOLS = 4;
  localparam int ZERO_FIXO = 1;

  typedef struct packed {
    logic       rst;
    logic       halt;
    logic [2:0] regLido1;
    logic [2:0] regLido2;
    logic [2:0] regEscrito;
    logic [2:0] regReservado;
    logic       sobrescrever;
    logic       reservar;
    logic [7:0] dadoEscrito;
    logic [1:0] boolLido1;
    logic [1:0] boolLido2;
    logic [1:0] boolEscrito;
    logic       sobrescreverBool;
    logic       dadoBoolEscrito;
  } stim_t;

  typedef struct packed {
    logic [7:0] dado1;
    logic [7:0] dado2;
    logic       dadoBool1;
    logic       dadoBool2;
    logic       ocupado1;
    logic       ocupado2;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  expQueue[$];
  string nameQueue[$];
  int    assertCount = 0;
  int    failCount   = 0;
  stim_t s;

  always #5 clk = ~clk;

  banco_registradores_param_if #(
    .LARGURA   (LARGURA),
    .NUM_REGS  (NUM_REGS),
    .NUM_BOOLS (NUM_BOOLS)
  ) bus ();

  banco_registradores_param #(
    .LARGURA   (LARGURA),
    .NUM_REGS  (NUM_REGS),
    .NUM_BOOLS (NUM_BOOLS),
    .ZERO_FIXO (ZERO_FIXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic exp_t mkExp(input logic [7:0] d1, input logic [7:0] d2,
                                 input logic b1, input logic b2,
                                 input logic o1, input logic o2);
    exp_t e;
    e.dado1 = d1; e.dado2 = d2;
    e.dadoBool1 = b1; e.dadoBool2 = b2;
    e.ocupado1 = o1; e.ocupado2 = o2;
    return e;
  endfunction

  // Drives one edge worth of inputs and queues what the outputs must be after that edge.
  task automatic applyStimulus(input stim_t st, input exp_t e, input string nome);
    rst                  = st.rst;
    bus.halt             = st.halt;
    bus.regLido1         = st.regLido1;
    bus.regLido2         = st.regLido2;
    bus.regEscrito       = st.regEscrito;
    bus.sobrescrever     = st.sobrescrever;
    bus.dadoEscrito      = st.dadoEscrito;
    bus.boolLido1        = st.boolLido1;
    bus.boolLido2        = st.boolLido2;
    bus.boolEscrito      = st.boolEscrito;
    bus.sobrescreverBool = st.sobrescreverBool;
    bus.dadoBoolEscrito  = st.dadoBoolEscrito;
    bus.reservar         = st.reservar;
    bus.regReservado     = st.regReservado;
    expQueue.push_back(e);
    nameQueue.push_back(nome);
    @(negedge clk);
  endtask

  task automatic checkField(input string nome, input string campo,
                            input logic [7:0] atual, input logic [7:0] esperado);
    assertCount++;
    if (atual !== esperado) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %h expected %h", nome, campo, atual, esperado);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string nome);
    checkField(nome, "dado1",     bus.dado1,            e.dado1);
    checkField(nome, "dado2",     bus.dado2,            e.dado2);
    checkField(nome, "dadoBool1", {7'b0, bus.dadoBool1}, {7'b0, e.dadoBool1});
    checkField(nome, "dadoBool2", {7'b0, bus.dadoBool2}, {7'b0, e.dadoBool2});
    checkField(nome, "ocupado1",  {7'b0, bus.ocupado1},  {7'b0, e.ocupado1});
    checkField(nome, "ocupado2",  {7'b0, bus.ocupado2},  {7'b0, e.ocupado2});
  endtask

  // Monitor: the bank produces a fresh result every edge, so one expectation is consumed per edge.
  initial begin
    exp_t  e;
    string nome;
    forever begin
      @(posedge clk);
      #1;
      if (expQueue.size() > 0) begin
        e    = expQueue.pop_front();
        nome = nameQueue.pop_front();
        checkOutput(e, nome);
      end
    end
  end

  initial begin
    s = '0; s.rst = 1'b1;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "reset");
    s.regLido1 = 3'd7; s.regLido2 = 3'd6; s.boolLido1 = 2'd3; s.boolLido2 = 2'd2;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "reset_reads");

    for (int i = 0; i < 8; i++) begin
      s = '0;
      s.regLido1 = 3'(i); s.regLido2 = 3'(7 - i);
      s.boolLido1 = 2'(i); s.boolLido2 = 2'(3 - (i % 4));
      applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "read_all");
    end

    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd3; s.dadoEscrito = 8'hA5;
    s.regLido1 = 3'd3; s.regLido2 = 3'd3;
    applyStimulus(s, mkExp(8'hA5, 8'hA5, 0, 0, 0, 0), "bypass_r3");
    s = '0; s.regLido1 = 3'd3;
    applyStimulus(s, mkExp(8'hA5, 8'h00, 0, 0, 0, 0), "hold_r3");

    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd0; s.dadoEscrito = 8'hFF;
    s.regLido1 = 3'd0; s.regLido2 = 3'd3;
    applyStimulus(s, mkExp(8'h00, 8'hA5, 0, 0, 0, 0), "zero_write");
    s = '0;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "zero_read");

    s = '0; s.reservar = 1; s.regReservado = 3'd5; s.regLido1 = 3'd5; s.regLido2 = 3'd3;
    applyStimulus(s, mkExp(8'h00, 8'hA5, 0, 0, 1, 0), "reserve_r5");
    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd5; s.dadoEscrito = 8'h3C; s.regLido1 = 3'd5;
    applyStimulus(s, mkExp(8'h3C, 8'h00, 0, 0, 0, 0), "write_r5");
    s.reservar = 1; s.regReservado = 3'd5; s.dadoEscrito = 8'h5A;
    applyStimulus(s, mkExp(8'h5A, 8'h00, 0, 0, 1, 0), "reserve_write_same");
    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd5; s.dadoEscrito = 8'h66;
    s.reservar = 1; s.regReservado = 3'd1; s.regLido1 = 3'd5; s.regLido2 = 3'd1;
    applyStimulus(s, mkExp(8'h66, 8'h00, 0, 0, 0, 1), "reserve_write_diff");

    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd2; s.dadoEscrito = 8'h22;
    s.sobrescreverBool = 1; s.boolEscrito = 2'd2; s.dadoBoolEscrito = 1;
    s.regLido1 = 3'd2; s.regLido2 = 3'd1; s.boolLido1 = 2'd2; s.boolLido2 = 2'd1;
    applyStimulus(s, mkExp(8'h22, 8'h00, 1, 0, 0, 1), "bool_write_b2");
    s = '0; s.reservar = 1; s.regReservado = 3'd0;
    s.regLido1 = 3'd0; s.regLido2 = 3'd1; s.boolLido1 = 2'd2; s.boolLido2 = 2'd1;
    applyStimulus(s, mkExp(8'h00, 8'h00, 1, 0, 0, 1), "reserve_r0");

    s = '0; s.halt = 1; s.sobrescrever = 1; s.regEscrito = 3'd2; s.dadoEscrito = 8'h11;
    s.sobrescreverBool = 1; s.boolEscrito = 2'd1; s.dadoBoolEscrito = 1;
    s.reservar = 1; s.regReservado = 3'd3;
    s.regLido1 = 3'd2; s.regLido2 = 3'd5; s.boolLido1 = 2'd1; s.boolLido2 = 2'd3;
    applyStimulus(s, mkExp(8'h00, 8'h00, 1, 0, 0, 1), "halt_hold1");
    applyStimulus(s, mkExp(8'h00, 8'h00, 1, 0, 0, 1), "halt_hold2");
    s = '0; s.regLido1 = 3'd2; s.regLido2 = 3'd3; s.boolLido1 = 2'd1; s.boolLido2 = 2'd2;
    applyStimulus(s, mkExp(8'h22, 8'hA5, 0, 1, 0, 0), "after_halt");
    s = '0; s.regLido1 = 3'd1; s.regLido2 = 3'd5;
    applyStimulus(s, mkExp(8'h00, 8'h66, 0, 0, 1, 0), "busy_r1");

    s = '0; s.rst = 1; s.halt = 1; s.sobrescrever = 1; s.regEscrito = 3'd4; s.dadoEscrito = 8'h99;
    s.reservar = 1; s.regReservado = 3'd4;
    s.sobrescreverBool = 1; s.boolEscrito = 2'd3; s.dadoBoolEscrito = 1;
    s.regLido1 = 3'd4; s.regLido2 = 3'd5; s.boolLido1 = 2'd3; s.boolLido2 = 2'd2;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "reset_halt");
    s = '0; s.regLido1 = 3'd1; s.regLido2 = 3'd5; s.boolLido1 = 2'd2; s.boolLido2 = 2'd3;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "post_reset_a");
    s = '0; s.regLido1 = 3'd4; s.regLido2 = 3'd3;
    applyStimulus(s, mkExp(8'h00, 8'h00, 0, 0, 0, 0), "post_reset_b");

    s = '0; s.sobrescrever = 1; s.regEscrito = 3'd7; s.dadoEscrito = 8'hC3;
    s.sobrescreverBool = 1; s.boolEscrito = 2'd3; s.dadoBoolEscrito = 1;
    s.regLido1 = 3'd7; s.regLido2 = 3'd7; s.boolLido1 = 2'd3; s.boolLido2 = 2'd3;
    applyStimulus(s, mkExp(8'hC3, 8'hC3, 1, 1, 0, 0), "write_r7_b3");
    s = '0; s.regLido1 = 3'd2; s.regLido2 = 3'd7;
    applyStimulus(s, mkExp(8'h00, 8'hC3, 0, 0, 0, 0), "read_r2_r7");

    for (int i = 0; i < 20 && expQueue.size() > 0; i++) @(posedge clk);
    #2;
    if (expQueue.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQueue.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
